// File: rtl/mips_pkg.sv
// Types and constants shared across the MIPS pipeline control blocks.
package mips_pkg;

    // Register file address width (32 architectural registers).
    localparam int REG_AW = 5;

    // Control word that ID_Stage_Reg loads when a bubble is inserted.
    typedef struct packed {
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] exe_cmd;
        logic       branch;
        logic       imm;
    } id_ctrl_t;

    // A NOP performs no write-back, no memory access and no branch.
    localparam id_ctrl_t NOP_CTRL = '0;

    // SRAM access sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } sram_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW detection, SRAM wait
// sequencing, branch squash and performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = mips_pkg::REG_AW,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              mem_access,
    input  logic              sram_ready,
    input  logic              branch_taken,
    output logic              freeze,
    output logic              if_flush,
    output logic              id_bubble,
    output logic              be_stall,
    output logic              mem_err,
    output logic [CNT_W-1:0]  hazard_cnt,
    output logic [CNT_W-1:0]  mem_stall_cnt
);

    import mips_pkg::*;

    // Wide enough to hold TIMEOUT-1; the counter parks there once reached.
    localparam int            TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    sram_state_t     state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic exe_hit;
    logic mem_hit;
    logic raw;
    logic hazard_en;

    // RAW detection: a write to r0 never creates a dependency, and src2 only
    // matters when the instruction actually reads it. With forwarding on, only
    // a load in EXE cannot be bypassed in time.
    always_comb begin
        exe_hit = exe_wb_en && (exe_dest != '0) &&
                  ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
        mem_hit = mem_wb_en && (mem_dest != '0) &&
                  ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
        if (fwd_en) begin
            raw = ~rst & id_valid & exe_hit & exe_mem_read;
        end else begin
            raw = ~rst & id_valid & (exe_hit | mem_hit);
        end
    end

    // Pipeline control outputs. A taken branch squashes the hazarding ID
    // instruction, so the flush takes priority over the freeze; a back-end
    // stall holds everything including the branch sitting in EXE.
    always_comb begin
        be_stall  = ~rst & (((state_q == S_IDLE) & mem_access & ~sram_ready) |
                            ((state_q == S_WAIT) & ~sram_ready));
        if_flush  = ~rst & branch_taken & ~be_stall;
        freeze    = be_stall | (raw & ~if_flush);
        id_bubble = ~be_stall & (raw | if_flush);
        hazard_en = raw & ~be_stall & ~if_flush;
    end

    // SRAM sequencer next state, wait timer and sticky timeout flag. DONE
    // absorbs one cycle so the completed access cannot re-arm the wait.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        mem_err_d = mem_err_q;
        case (state_q)
            S_IDLE: begin
                if (mem_access && !sram_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sram_ready) begin
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
                end
                if (to_cnt_q == TO_MAX) begin
                    mem_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(
        .W(CNT_W)
    ) u_hazard_cnt (
        .clk  (clk),
        .clr  (rst),
        .en   (hazard_en),
        .count(hazard_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_mem_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .en   (be_stall),
        .count(mem_stall_cnt)
    );

endmodule
